// File: rtl/uart_tx_sched.sv
// uart_tx_sched: frames bytes from N_REQ requesters onto a single uart_tx.
//
// Each frame is SYNC_BYTE, a header carrying the owner's index, the owner's
// payload bytes (passed straight through, zero latency), then an XOR checksum
// over the header and payload. Ownership is round-robin and a frame runs to
// completion before anyone else is considered. A frame that reaches MAX_LEN
// payload bytes without req_last is closed early and flagged with trunc. The
// rest of that message goes out in a later frame.
//
// Ports
//   clk        single clock
//   rst        asynchronous active-high reset, release synchronised internally
//   req_data   N_REQ packed bytes, requester i at [i*BITS_N +: BITS_N]
//   req_valid  per-requester byte valid
//   req_last   per-requester last-byte-of-message flag
//   req_ready  per-requester byte accepted (only the owner, only in PAYLOAD)
//   tx_data    byte to uart_tx
//   tx_valid   byte valid to uart_tx
//   tx_ready   uart_tx can accept a byte
//   grant_id   index of the requester owning the current frame
//   busy       high whenever a frame is in progress
//   trunc      one-cycle pulse when a frame was closed at MAX_LEN

// Per-requester handshake: the owner sees tx_ready during PAYLOAD, all
// other requesters see 0.
module uart_tx_sched_lane #(
  parameter int GW  = 2,
  parameter int IDX = 0
) (
  input  logic          sel,
  input  logic [GW-1:0] grant_id,
  input  logic          tx_ready,
  output logic          ready
);
  assign ready = sel && (grant_id == GW'(IDX)) && tx_ready;
endmodule

module uart_tx_sched #(
  parameter int                N_REQ     = 4,
  parameter int                BITS_N    = 8,
  parameter logic [BITS_N-1:0] SYNC_BYTE = 8'hA5,
  parameter int                MAX_LEN   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ*BITS_N-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic [BITS_N-1:0]         tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy,
  output logic                      trunc
);

  localparam int          GW = $clog2(N_REQ);
  localparam int          LW = $clog2(MAX_LEN+1);
  localparam int unsigned NR = N_REQ;
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_HDR,
    S_PAYLOAD,
    S_CSUM
  } state_t;

  state_t                     state, state_nxt;
  logic [1:0]                 rel_q;
  logic [GW-1:0]              rr_ptr;
  logic [BITS_N-1:0]          csum;
  logic [LW-1:0]              len;

  logic [N_REQ-1:0][BITS_N-1:0] req_bytes;
  logic [BITS_N-1:0]          g_data;
  logic                       g_valid;
  logic                       g_last;
  logic [BITS_N-1:0]          hdr_byte;
  logic [LW-1:0]              len_inc;
  logic                       len_hit;
  logic                       pay_xfer;
  logic                       pay_sel;
  logic                       arb_hit;
  logic [GW-1:0]              arb_idx;
  logic                       arb_go;

  // (base + off) mod N_REQ, valid for off < N_REQ.
  function automatic logic [GW-1:0] idx_wrap(input logic [GW-1:0] base,
                                             input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NR) s = s - NR;
    return GW'(s);
  endfunction

  // Reset release is delayed two clk edges so arbitration never sees a
  // partially released design; assertion still takes effect immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rel_q <= 2'b00;
    else     rel_q <= {rel_q[0], 1'b1};
  end

  // Owner's view of its request, selected by the registered grant.
  assign req_bytes = req_data;
  assign g_data    = req_bytes[grant_id];
  assign g_valid   = req_valid[grant_id];
  assign g_last    = req_last[grant_id];
  assign hdr_byte  = BITS_N'(grant_id);

  assign len_inc  = len + LW'(1);
  assign len_hit  = (len_inc == LEN_MAX);
  assign pay_xfer = (state == S_PAYLOAD) && g_valid && tx_ready;

  // Round-robin search: first valid requester at or after rr_ptr.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      if (!arb_hit && req_valid[idx_wrap(rr_ptr, k)]) begin
        arb_hit = 1'b1;
        arb_idx = idx_wrap(rr_ptr, k);
      end
    end
  end

  assign arb_go = (state == S_IDLE) && rel_q[1] && arb_hit;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (arb_go)   state_nxt = S_SYNC;
      S_SYNC:    if (tx_ready) state_nxt = S_HDR;
      S_HDR:     if (tx_ready) state_nxt = S_PAYLOAD;
      S_PAYLOAD: if (pay_xfer && (g_last || len_hit)) state_nxt = S_CSUM;
      S_CSUM:    if (tx_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output logic. PAYLOAD is a pure pass-through of the owner's byte, so
  // tx stability during a stall there relies on the requester holding.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = '0;
    pay_sel  = 1'b0;
    case (state)
      S_SYNC: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
      end
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = hdr_byte;
      end
      S_PAYLOAD: begin
        tx_valid = g_valid;
        tx_data  = g_data;
        pay_sel  = 1'b1;
      end
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_lane
      uart_tx_sched_lane #(.GW(GW), .IDX(gi)) u_lane (
        .sel      (pay_sel),
        .grant_id (grant_id),
        .tx_ready (tx_ready),
        .ready    (req_ready[gi])
      );
    end
  endgenerate

  // Frame datapath: owner, fairness pointer, running checksum, length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id <= '0;
      rr_ptr   <= '0;
      csum     <= '0;
      len      <= '0;
      trunc    <= 1'b0;
    end else begin
      trunc <= 1'b0;
      if (arb_go) grant_id <= arb_idx;
      if (state == S_HDR && tx_ready) begin
        csum <= hdr_byte;
        len  <= '0;
      end
      if (pay_xfer) begin
        csum  <= csum ^ g_data;
        len   <= len_inc;
        // Closed by length alone: the message continues in a later frame.
        trunc <= len_hit && !g_last;
      end
      if (state == S_CSUM && tx_ready) rr_ptr <= idx_wrap(grant_id, 1);
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

  localparam int NQ = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NQ*8-1:0] req_data;
  logic [NQ-1:0]   req_valid;
  logic [NQ-1:0]   req_last;
  logic [NQ-1:0]   req_ready;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [1:0]      grant_id;
  logic            busy;
  logic            trunc;

  uart_tx_sched #(.N_REQ(NQ), .BITS_N(8), .SYNC_BYTE(8'hA5), .MAX_LEN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .trunc     (trunc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // requester model: byte lists with per-byte last flags
  logic [7:0] rq_b [NQ][8];
  logic       rq_l [NQ][8];
  int         rq_n [NQ];
  int         rq_p [NQ];
  logic [7:0] ld_q [$];
  logic [7:0] exp_q [$];

  // monitor state
  logic [7:0] txq [$];
  logic [1:0] grq [$];
  logic [NQ-1:0] req_acc = '0;
  logic       prev_busy = 1'b0;
  logic       stall_v = 1'b0;
  logic [7:0] stall_d = '0;
  int         stab_err = 0;
  int         busy_cnt = 0;
  int         trunc_cnt = 0;
  bit         tr_toggle = 1'b0;

  always @(negedge clk) begin
    req_acc   <= req_valid & req_ready;
    prev_busy <= busy;
    busy_cnt  <= busy_cnt + int'(busy);
    trunc_cnt <= trunc_cnt + int'(trunc);
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    if (busy && !prev_busy) grq.push_back(grant_id);
    if (stall_v && !rst && (tx_valid !== 1'b1 || tx_data !== stall_d))
      stab_err <= stab_err + 1;
    stall_v <= tx_valid && !tx_ready && !rst;
    stall_d <= tx_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_req();
    for (int i = 0; i < NQ; i++) begin
      if (rq_p[i] < rq_n[i]) begin
        req_valid[i]       = 1'b1;
        req_last[i]        = rq_l[i][rq_p[i]];
        req_data[i*8 +: 8] = rq_b[i][rq_p[i]];
      end else begin
        req_valid[i]       = 1'b0;
        req_last[i]        = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
      end
    end
  endtask

  task automatic load_req(input int i, input logic [7:0] lmask);
    for (int k = 0; k < ld_q.size(); k++) begin
      rq_b[i][k] = ld_q[k];
      rq_l[i][k] = lmask[k];
    end
    rq_n[i] = ld_q.size();
    rq_p[i] = 0;
    apply_req();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    for (int i = 0; i < NQ; i++) if (req_acc[i]) rq_p[i]++;
    if (tr_toggle) tx_ready = ~tx_ready;
    apply_req();
  endtask

  task automatic wait_tx(input string tag, input int n, input int budget);
    int c = 0;
    while (txq.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk({tag, "_count"}, txq.size(), n);
  endtask

  task automatic chk_seq(input string tag);
    for (int k = 0; k < exp_q.size(); k++)
      chk($sformatf("%s_b%0d", tag, k), (k < txq.size()) ? {24'h0, txq[k]} : 32'hx, {24'h0, exp_q[k]});
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int bb, tb0, c;
    rst = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < NQ; i++) begin rq_n[i] = 0; rq_p[i] = 0; end
    req_data = '0; req_valid = '0; req_last = '0;
    apply_req();

    // reset state, with a request already pending
    ld_q = {8'h3C};
    load_req(2, 8'h01);
    tick(); tick(); tick();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_trunc", trunc, 0);
    chk("rst_grant", grant_id, 0);

    // single-byte frame; no grant on the first edge after release
    bb = busy_cnt;
    rst = 1'b0;
    tick();
    chk("rel_edge1_busy", busy, 0);
    wait_tx("t1", 4, 30);
    tick(); tick();
    exp_q = {8'hA5, 8'h02, 8'h3C, 8'h3E};
    chk_seq("t1");
    chk("t1_busy_cycles", busy_cnt - bb, 4);
    chk("t1_grant", (grq.size() > 0) ? 32'(grq[0]) : 32'hx, 2);
    chk("t1_idle", busy, 0);

    // round robin from rr_ptr=0 with everyone requesting
    pulse_reset();
    txq.delete(); grq.delete();
    ld_q = {8'h10, 8'h14}; load_req(0, 8'b11);
    ld_q = {8'h11};        load_req(1, 8'b1);
    ld_q = {8'h12};        load_req(2, 8'b1);
    ld_q = {8'h13};        load_req(3, 8'b1);
    wait_tx("t2", 20, 120);
    tick(); tick();
    chk("t2_ngrants", grq.size(), 5);
    for (int k = 0; k < 5; k++)
      chk($sformatf("t2_grant%0d", k), (k < grq.size()) ? 32'(grq[k]) : 32'hx, (k == 4) ? 0 : k);
    exp_q = {8'hA5, 8'h00, 8'h10, 8'h10, 8'hA5, 8'h01, 8'h11, 8'h10};
    chk_seq("t2");
    chk("t2_last_payload", (txq.size() > 18) ? 32'(txq[18]) : 32'hx, 32'h14);

    // backpressure: tx_ready toggles each cycle
    txq.delete(); grq.delete();
    tr_toggle = 1'b1;
    ld_q = {8'hA1, 8'hB2, 8'hC3};
    load_req(1, 8'b100);
    wait_tx("t3", 6, 80);
    tr_toggle = 1'b0;
    tx_ready = 1'b1;
    tick(); tick(); tick();
    exp_q = {8'hA5, 8'h01, 8'hA1, 8'hB2, 8'hC3, 8'hD1};
    chk_seq("t3");
    chk("t3_no_extra", txq.size(), 6);
    chk("t3_stall_hold", stab_err, 0);

    // truncation at MAX_LEN=4, message continues in a second frame
    txq.delete(); grq.delete();
    tb0 = trunc_cnt;
    ld_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    load_req(1, 8'b100000);
    wait_tx("t4", 12, 80);
    tick(); tick();
    exp_q = {8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
             8'hA5, 8'h01, 8'h05, 8'h06, 8'h02};
    chk_seq("t4");
    chk("t4_trunc_pulses", trunc_cnt - tb0, 1);

    // reset mid-payload after the second payload byte
    txq.delete(); grq.delete();
    ld_q = {8'h31, 8'h32, 8'h33, 8'h34};
    load_req(3, 8'b1000);
    wait_tx("t5a", 4, 40);
    chk("t5_pre_valid", tx_valid, 1);
    rst = 1'b1;
    #1;
    chk("t5_async_valid", tx_valid, 0);
    chk("t5_async_ready", req_ready, 0);
    chk("t5_async_busy", busy, 0);
    tick(); tick();
    txq.delete(); grq.delete();
    ld_q = {8'h55};
    load_req(2, 8'b1);
    rst = 1'b0;
    wait_tx("t5b", 9, 80);
    tick(); tick();
    exp_q = {8'hA5, 8'h02, 8'h55, 8'h57, 8'hA5, 8'h03, 8'h33, 8'h34, 8'h04};
    chk_seq("t5");
    chk("t5_grant0", (grq.size() > 0) ? 32'(grq[0]) : 32'hx, 2);
    chk("t5_grant1", (grq.size() > 1) ? 32'(grq[1]) : 32'hx, 3);

    // contention: requester 3 waits for requester 0's checksum
    txq.delete(); grq.delete();
    ld_q = {8'h40, 8'h41};
    load_req(0, 8'b10);
    c = 0;
    while (!busy && c < 10) begin tick(); c++; end
    chk("t6_busy", busy, 1);
    ld_q = {8'h77};
    load_req(3, 8'b1);
    c = 0;
    while (txq.size() < 5 && c < 40) begin
      chk("t6_ready3_blocked", req_ready[3], 0);
      tick();
      c++;
    end
    wait_tx("t6", 9, 40);
    tick(); tick();
    exp_q = {8'hA5, 8'h00, 8'h40, 8'h41, 8'h01, 8'hA5, 8'h03, 8'h77, 8'h74};
    chk_seq("t6");
    chk("t6_grant0", (grq.size() > 0) ? 32'(grq[0]) : 32'hx, 0);
    chk("t6_grant1", (grq.size() > 1) ? 32'(grq[1]) : 32'hx, 3);
    chk("final_stall_hold", stab_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesters sharing one uart_tx (2..8).
REQ-002 Parameter: BITS_N, default 8, byte width; matches uart_tx BITS_N.
REQ-003 Parameter: SYNC_BYTE, default 8'hA5, frame start marker.
REQ-004 Parameter: MAX_LEN, default 16, maximum payload bytes per frame (1..255).
REQ-005 Port list, one per line, in this order:
- clk  input  1  single clock.
- rst  input  1  reset; asynchronous, active-high.
- req_data  input  N_REQ*BITS_N  per-requester byte; requester i occupies bits [i*BITS_N +: BITS_N].
- req_valid  input  N_REQ  per-requester byte valid.
- req_last  input  N_REQ  per-requester last-byte-of-message flag.
- req_ready  output  N_REQ  per-requester byte accepted.
- tx_data  output  BITS_N  byte to uart_tx data_tx.
- tx_valid  output  1  to uart_tx valid_in.
- tx_ready  input  1  from uart_tx ready_out.
- grant_id  output  $clog2(N_REQ)  index of the requester owning the current frame.
- busy  output  1  high in every state except IDLE.
- trunc  output  1  one-cycle pulse when a frame is closed at MAX_LEN without req_last.

Function
REQ-006 A byte transfers on tx only in a cycle with tx_valid=1 and tx_ready=1. A requester byte transfers only in a cycle with req_valid[i]=1 and req_ready[i]=1.
REQ-007 FSM states: IDLE, SYNC, HDR, PAYLOAD, CSUM.
REQ-008 IDLE:
- If any req_valid is set, grant the first set bit searching round-robin from rr_ptr upward, wrapping at N_REQ-1 to 0.
- Register the granted index into grant_id and go to SYNC next cycle.
- tx_valid=0 in IDLE.
REQ-009 SYNC:
- tx_data=SYNC_BYTE, tx_valid=1.
- On transfer, go to HDR.
REQ-010 HDR:
- tx_data = zero-extended grant_id, tx_valid=1.
- On transfer, load csum=header byte, clear len, go to PAYLOAD.
REQ-011 PAYLOAD is a zero-latency combinational pass-through for requester g=grant_id:
- tx_data = req_data[g].
- tx_valid = req_valid[g].
- req_ready[g] = tx_ready.
- All other req_ready bits = 0.
REQ-012 PAYLOAD, on each transfer:
- csum <= csum XOR byte; len <= len+1.
- Go to CSUM if req_last[g]=1 or len+1 == MAX_LEN; otherwise stay in PAYLOAD.
REQ-013 If a frame closes at MAX_LEN with req_last[g]=0, pulse trunc for one cycle. The remaining bytes are sent as a new frame after re-arbitration.
REQ-014 CSUM:
- tx_data = csum, tx_valid=1.
- On transfer: rr_ptr <= (grant_id+1) mod N_REQ; go to IDLE.
REQ-015 req_ready = 0 in every state except PAYLOAD.
REQ-016 tx_data and tx_valid must not change while tx_valid=1 and tx_ready=0. Exception: in PAYLOAD they follow the requester, which must itself hold stable.
REQ-017 Requests from non-granted requesters have no effect until the frame ends. No preemption.
REQ-018 A deasserted req_valid[g] mid-frame stalls in PAYLOAD indefinitely; there is no timeout.
REQ-019 len is $clog2(MAX_LEN+1) bits wide; csum is BITS_N bits wide; all arithmetic is unsigned.
REQ-020 Minimum frame is SYNC, HDR, 1 payload byte, CSUM: 4 tx transfers.

Reset
REQ-021 While rst=1, asynchronously and independent of clk:
- state=IDLE, rr_ptr=0, grant_id=0, csum=0, len=0.
- tx_valid=0, tx_data=0, req_ready=0, busy=0, trunc=0.
REQ-022 Reset asserted mid-frame abandons the frame. No checksum is sent, and the first frame after reset begins with SYNC.
REQ-023 Deassertion is internally synchronised (two-flop release on clk); the first arbitration occurs no earlier than the second clk edge after rst falls.

Verification
REQ-024 Single-byte frame: requester 2 sends 8'h3C with last=1, tx_ready tied 1 -> tx sequence A5, 02, 3C, 3E; busy=1 for 4 cycles after grant.
REQ-025 Round-robin: all four req_valid held high with one-byte messages -> grant order 0,1,2,3,0; no requester is granted twice consecutively.
REQ-026 Backpressure: tx_ready toggles 1/0 each cycle -> tx_data stable while tx_ready=0; bytes neither lost nor duplicated; checksum correct.
REQ-027 Truncation: MAX_LEN=4, requester 1 streams 6 bytes 01..06 with last on 06 ->
- frame 1: A5, 01, 01..04, csum 05; trunc pulses once.
- frame 2: A5, 01, 05, 06, csum 02.
REQ-028 Reset mid-PAYLOAD: assert rst after the second payload byte -> tx_valid and req_ready drop immediately without a clock; next frame starts with A5 granted from rr_ptr=0.
REQ-029 Mid-frame contention: requester 3 raises valid while requester 0 owns the frame -> req_ready[3] stays 0 until requester 0's CSUM transfers, then requester 3 is granted.
